// File: rtl/bert_rx_checker_if.sv
// Receive byte stream into the PRBS-7 checker.
interface bert_rx_checker_if;
    logic [7:0] data;
    logic       valid;

    modport master (output data, output valid);
    modport slave  (input  data, input  valid);
endinterface

// File: rtl/bert_rx_checker.sv
// PRBS-7 receive checker: acquires lock on the incoming byte stream
// and accumulates windowed bit and error counts while locked.
module bert_rx_checker #(
    parameter int VERIFY_BYTES = 4,
    parameter int LOSS_BYTES   = 4,
    parameter int LOSS_THRESH  = 2,
    parameter int WINDOW_BYTES = 1024
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    clear_i,
    bert_rx_checker_if.slave        rx_if,
    output logic                    locked_o,
    output logic [1:0]              sync_state_o,
    output logic [3:0]              byte_errors_o,
    output logic [31:0]             bit_count_o,
    output logic [31:0]             error_count_o,
    output logic                    window_done_o
);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_e;

    localparam logic [31:0] WIN_BITS = 32'(WINDOW_BYTES * 8);

    state_e      state_q, state_d;
    logic [6:0]  lfsr_q, lfsr_d;
    logic [15:0] clean_q, clean_d;
    logic [15:0] bad_q, bad_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] bit_cnt_q, bit_cnt_d;
    logic [31:0] err_cnt_q, err_cnt_d;
    logic        wd_q, wd_d;
    logic        frozen_q, frozen_d;

    logic [14:0] step;
    logic [7:0]  pred;
    logic [3:0]  mism;
    logic        check;
    logic        count_en;
    logic [31:0] bit_sum;
    logic [31:0] err_sum;

    // Returns {lfsr after 8 shifts, predicted byte}; bit 7 is predicted first.
    function automatic logic [14:0] prbs_step(input logic [6:0] s);
        logic [6:0] st;
        logic [7:0] p;
        logic       nb;
        st = s;
        p  = '0;
        for (int i = 7; i >= 0; i--) begin
            nb   = st[6] ^ st[5];
            p[i] = nb;
            st   = {st[5:0], nb};
        end
        return {st, p};
    endfunction

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < 8; i++) begin
            c = c + {3'd0, v[i]};
        end
        return c;
    endfunction

    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    assign step = prbs_step(lfsr_q);
    assign pred = step[7:0];
    assign mism = popcount8(rx_if.data ^ pred);

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        clean_d = clean_q;
        bad_d   = bad_q;
        be_d    = be_q;
        check   = 1'b0;
        if (rx_if.valid) begin
            unique case (state_q)
                HUNT: begin
                    lfsr_d  = rx_if.data[6:0];
                    clean_d = '0;
                    state_d = VERIFY;
                end
                VERIFY: begin
                    lfsr_d = step[14:8];
                    be_d   = mism;
                    if (mism == 4'd0) begin
                        clean_d = clean_q + 16'd1;
                        if (clean_d == 16'(VERIFY_BYTES)) begin
                            state_d = LOCKED;
                            bad_d   = '0;
                        end
                    end else begin
                        clean_d = '0;
                        state_d = HUNT;
                    end
                end
                LOCKED: begin
                    lfsr_d = step[14:8];
                    be_d   = mism;
                    check  = 1'b1;
                    if (mism >= 4'(LOSS_THRESH)) begin
                        bad_d = bad_q + 16'd1;
                    end else begin
                        bad_d = '0;
                    end
                    if (bad_d == 16'(LOSS_BYTES)) begin
                        bad_d   = '0;
                        state_d = HUNT;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    // Counting stops once a window completes and stays stopped until clear.
    assign count_en = check && !clear_i && !frozen_q;
    assign bit_sum  = sat_add(bit_cnt_q, 32'd8);
    assign err_sum  = sat_add(err_cnt_q, {28'd0, mism});

    always_comb begin
        bit_cnt_d = bit_cnt_q;
        err_cnt_d = err_cnt_q;
        wd_d      = 1'b0;
        frozen_d  = frozen_q;
        if (clear_i) begin
            bit_cnt_d = '0;
            err_cnt_d = '0;
            frozen_d  = 1'b0;
        end else if (count_en) begin
            bit_cnt_d = bit_sum;
            err_cnt_d = err_sum;
            if (bit_sum == WIN_BITS) begin
                wd_d     = 1'b1;
                frozen_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= HUNT;
            lfsr_q    <= '0;
            clean_q   <= '0;
            bad_q     <= '0;
            be_q      <= '0;
            bit_cnt_q <= '0;
            err_cnt_q <= '0;
            wd_q      <= 1'b0;
            frozen_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            lfsr_q    <= lfsr_d;
            clean_q   <= clean_d;
            bad_q     <= bad_d;
            be_q      <= be_d;
            bit_cnt_q <= bit_cnt_d;
            err_cnt_q <= err_cnt_d;
            wd_q      <= wd_d;
            frozen_q  <= frozen_d;
        end
    end

    assign locked_o      = (state_q == LOCKED);
    assign sync_state_o  = state_q;
    assign byte_errors_o = be_q;
    assign bit_count_o   = bit_cnt_q;
    assign error_count_o = err_cnt_q;
    assign window_done_o = wd_q;

endmodule

// File: doc/bert_rx_checker.md
BERT_RX_CHECKER -- requirements
Module: bert_rx_checker

Interface
REQ-001 Parameter VERIFY_BYTES, default 4: consecutive error-free bytes required in VERIFY before declaring lock.
REQ-002 Parameter LOSS_BYTES, default 4: consecutive bad bytes in LOCKED before lock is dropped.
REQ-003 Parameter LOSS_THRESH, default 2: minimum bit errors in one byte for that byte to count as bad.
REQ-004 Parameter WINDOW_BYTES, default 1024: measurement window length in locked, valid bytes.
REQ-005 clock  input  1  single clock; all logic on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 data_in  input  8  received PRBS byte; bit 7 is the earliest bit in time.
REQ-008 data_valid  input  1  data_in is valid this cycle; bytes without it are ignored.
REQ-009 clear  input  1  synchronous clear of counters and window; does not affect lock state.
REQ-010 locked  output  1  high while the FSM is in LOCKED.
REQ-011 sync_state  output  2  FSM state: 0 HUNT, 1 VERIFY, 2 LOCKED.
REQ-012 byte_errors  output  4  bit-error count of the last checked byte, range 0..8.
REQ-013 bit_count  output  32  bits checked in LOCKED in the current window.
REQ-014 error_count  output  32  bit errors in LOCKED in the current window.
REQ-015 window_done  output  1  one-cycle pulse when the window completes.

Function
REQ-016 Pattern is PRBS-7, x^7+x^6+1: serial bit s[n] = s[n-6] XOR s[n-7], 8 bits per valid byte.
REQ-017 Local 7-bit LFSR holds the 7 most recent expected bits; it advances 8 bits per valid byte and never on an invalid cycle.
REQ-018 HUNT: on a valid byte, load the LFSR from data_in[6:0]; go to VERIFY; reset the clean-byte count to 0.
REQ-019 VERIFY: compare each valid byte with the 8 predicted bits; if there are 0 mismatches, increment the clean count, else return to HUNT; on clean count = VERIFY_BYTES, go to LOCKED.
REQ-020 LOCKED: the LFSR free-runs from its own state and is never reloaded from data; byte_errors = popcount(data_in XOR predicted).
REQ-021 LOCKED: a byte with byte_errors >= LOSS_THRESH increments the bad count, otherwise clears it; on bad count = LOSS_BYTES, go to HUNT.
REQ-022 byte_errors, locked and sync_state are registered, with 1-cycle latency from the valid byte; byte_errors holds its value on invalid cycles.
REQ-023 Counters update only for valid bytes that are checked in LOCKED, including the byte that causes lock loss; bit_count += 8 and error_count += byte_errors.
REQ-024 Both counters saturate at 32'hFFFFFFFF and never wrap.
REQ-025 When bit_count reaches WINDOW_BYTES*8, window_done pulses for exactly one cycle, coincident with the final count update.
REQ-026 After window_done, both counters freeze until clear, even while the FSM keeps tracking lock.
REQ-027 clear zeroes bit_count and error_count and re-arms the window on the next edge.
REQ-028 If clear and data_valid occur in the same cycle, clear wins and that byte is not counted; the FSM still processes the byte.
REQ-029 Lock loss does not clear the counters; re-lock resumes accumulating from the held values.

Reset
REQ-030 When reset is high: sync_state=HUNT, locked=0, byte_errors=0, bit_count=0, error_count=0, window_done=0, LFSR=0, and clean and bad counts=0.
REQ-031 reset overrides clear and data_valid in the same cycle.
REQ-032 reset during LOCKED returns the block to HUNT on the next edge, and the following valid byte restarts acquisition.

Verification
REQ-033 Clean PRBS-7 stream, 1 byte/cycle, defaults -> HUNT, then VERIFY, then locked=1 within 6 cycles of the first valid byte; byte_errors=0 afterwards; bit_count=8 per byte.
REQ-034 Locked, then flip 1 bit in a single byte -> byte_errors=1 for one cycle; error_count +1; lock held.
REQ-035 Locked, then 4 consecutive bytes with 3 flipped bits each -> error_count +12, then sync_state=HUNT after the 4th byte, and re-lock once clean data resumes.
REQ-036 Locked, WINDOW_BYTES=16, 16 clean bytes -> window_done pulses once with bit_count=128; counters then stay at 128/0 despite further bytes; clear gives 0/0.
REQ-037 data_valid toggled 0/1 every cycle on a clean stream -> lock is still acquired and no errors occur, proving the LFSR advances only on valid bytes.
REQ-038 Counters preloaded by force to 32'hFFFFFFF8 with errors injected -> bit_count sticks at 32'hFFFFFFFF; reset mid-lock -> all outputs are 0 on the next cycle.
